// File: rtl/pep_mmacc_splitc_sxt_sched_if.sv
// ---------------------------------------------------------------------------
// pep_mmacc_splitc_sxt_sched_if
//   Bundles the command, per-lane command, lane-done and synchronized-done
//   signals of the sign-extension split scheduler.
//
//   Handshake rule for every vld/rdy pair in this bundle: a transfer happens
//   on a rising clk edge where vld && rdy are both 1. Once a producer raises
//   vld it keeps vld and its payload stable until that edge. rdy may depend
//   on anything, but the producer never waits on rdy before raising vld.
//
//   Signals (direction as seen from the scheduler, modport slave):
//     in_cmd_vld   in   command offered upstream
//     in_cmd_rdy   out  scheduler can take a command
//     in_cmd_id    in   ID_W command ID
//     lane_cmd_vld out  IN_NB per-lane command valid
//     lane_cmd_rdy in   IN_NB per-lane command ready
//     lane_cmd_id  out  ID_W held command ID, shared by all lanes
//     lane_done    in   IN_NB one-cycle completion pulse per lane
//     out_done_vld out  synchronized completion valid
//     out_done_rdy in   synchronized completion ready
//     out_done_id  out  ID_W ID of the completed command
//     outstd_cnt   out  number of commands in flight
//   modport master is the mirror image (upstream + lanes + done consumer).
// ---------------------------------------------------------------------------
interface pep_mmacc_splitc_sxt_sched_if #(
    parameter int IN_NB      = 2,
    parameter int OUTSTD_MAX = 4,
    parameter int ID_W       = 8
);
    localparam int CNT_W = $clog2(OUTSTD_MAX + 1);

    logic              in_cmd_vld;
    logic              in_cmd_rdy;
    logic [ID_W-1:0]   in_cmd_id;
    logic [IN_NB-1:0]  lane_cmd_vld;
    logic [IN_NB-1:0]  lane_cmd_rdy;
    logic [ID_W-1:0]   lane_cmd_id;
    logic [IN_NB-1:0]  lane_done;
    logic              out_done_vld;
    logic              out_done_rdy;
    logic [ID_W-1:0]   out_done_id;
    logic [CNT_W-1:0]  outstd_cnt;

    modport slave (
        input  in_cmd_vld, in_cmd_id,
        output in_cmd_rdy,
        output lane_cmd_vld, lane_cmd_id,
        input  lane_cmd_rdy, lane_done,
        output out_done_vld, out_done_id,
        input  out_done_rdy,
        output outstd_cnt
    );

    modport master (
        output in_cmd_vld, in_cmd_id,
        input  in_cmd_rdy,
        input  lane_cmd_vld, lane_cmd_id,
        output lane_cmd_rdy, lane_done,
        input  out_done_vld, out_done_id,
        output out_done_rdy,
        input  outstd_cnt
    );
endinterface

// File: rtl/pep_mmacc_splitc_sxt_sched.sv
// ---------------------------------------------------------------------------
// pep_mmacc_splitc_sxt_sched
//   Forks each incoming command to IN_NB sign-extension lanes and joins their
//   completions back into one in-order done stream.
//
//   - Issue FSM (IDLE/ISSUE): holds one command and broadcasts it; each lane
//     handshakes independently and drops its valid once served.
//   - ID FIFO (depth OUTSTD_MAX): records fully issued commands in order.
//   - Per-lane done counters: a done is released (sync-pop) only when every
//     lane has at least one completion pending.
//   - outstd_cnt tracks commands between input accept and done accept.
//
//   Ports:
//     clk        rising-edge clock
//     s_rst_n    synchronous active-low reset
//     bus        pep_mmacc_splitc_sxt_sched_if.slave (see interface header)
//     dbg_state  current issue FSM state (0 = IDLE, 1 = ISSUE)
// ---------------------------------------------------------------------------
module pep_mmacc_splitc_sxt_sched #(
    parameter int IN_NB      = 2,
    parameter int OUTSTD_MAX = 4,
    parameter int ID_W       = 8
) (
    input  logic                               clk,
    input  logic                               s_rst_n,
    pep_mmacc_splitc_sxt_sched_if.slave        bus,
    output logic                               dbg_state
);
    localparam int CNT_W = $clog2(OUTSTD_MAX + 1);
    localparam int PTR_W = (OUTSTD_MAX > 1) ? $clog2(OUTSTD_MAX) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [IN_NB-1:0]  sent;
    logic [IN_NB-1:0]  sent_nxt;
    logic [IN_NB-1:0]  lane_hs;
    logic [ID_W-1:0]   cmd_id;
    logic              in_rdy;
    logic              in_acc;
    logic              all_sent;
    logic              fifo_push;
    logic              sync_pop;
    logic              done_acc;
    logic              all_cnt_nz;

    logic [CNT_W-1:0]  outstd_cnt;
    logic [CNT_W-1:0]  done_cnt [IN_NB];

    logic [ID_W-1:0]   fifo_mem [OUTSTD_MAX];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              out_vld;
    logic [ID_W-1:0]   out_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTD_MAX - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    // Ready depends on registers only, so upstream never sees a combinational
    // path from any of our inputs.
    assign in_rdy = (state == ST_IDLE) && (outstd_cnt < CNT_W'(OUTSTD_MAX));
    assign in_acc = bus.in_cmd_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state <= ST_IDLE;
            sent  <= '0;
        end else begin
            state <= state_nxt;
            sent  <= sent_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sent_nxt  = sent;
        lane_hs   = '0;
        all_sent  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_acc) begin
                    sent_nxt  = '0;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lane_hs  = ~sent & bus.lane_cmd_rdy;
                sent_nxt = sent | lane_hs;
                // Same-cycle handshakes count, so the last lanes served this
                // cycle finish the broadcast immediately.
                all_sent = &sent_nxt;
                if (all_sent) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command ID is payload: only meaningful while a valid qualifies it.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            cmd_id <= bus.in_cmd_id;
        end
    end

    assign bus.in_cmd_rdy   = in_rdy;
    assign bus.lane_cmd_vld = (state == ST_ISSUE) ? ~sent : '0;
    assign bus.lane_cmd_id  = cmd_id;
    assign dbg_state        = state;

    // ------------------------------------------------------------------
    // Per-lane done counters and join
    // ------------------------------------------------------------------
    always_comb begin
        all_cnt_nz = 1'b1;
        for (int i = 0; i < IN_NB; i++) begin
            if (done_cnt[i] == '0) begin
                all_cnt_nz = 1'b0;
            end
        end
    end

    assign done_acc = out_vld && bus.out_done_rdy;
    assign sync_pop = all_cnt_nz && (!out_vld || bus.out_done_rdy);

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            for (int i = 0; i < IN_NB; i++) begin
                done_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_NB; i++) begin
                case ({bus.lane_done[i], sync_pop})
                    2'b10:   done_cnt[i] <= done_cnt[i] + CNT_W'(1);
                    2'b01:   done_cnt[i] <= done_cnt[i] - CNT_W'(1);
                    default: done_cnt[i] <= done_cnt[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // ID FIFO: push when broadcast completes, pop on sync-pop
    // ------------------------------------------------------------------
    assign fifo_push = all_sent;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (sync_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({fifo_push, sync_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= cmd_id;
        end
    end

    // ------------------------------------------------------------------
    // Done output register: a pop refills it in the same cycle the consumer
    // takes the current entry, giving one done per cycle when drained.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            out_vld <= 1'b0;
        end else if (sync_pop) begin
            out_vld <= 1'b1;
        end else if (bus.out_done_rdy) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_pop) begin
            out_id <= fifo_mem[rd_ptr];
        end
    end

    assign bus.out_done_vld = out_vld;
    assign bus.out_done_id  = out_id;

    // ------------------------------------------------------------------
    // In-flight counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            outstd_cnt <= '0;
        end else begin
            case ({in_acc, done_acc})
                2'b10:   outstd_cnt <= outstd_cnt + CNT_W'(1);
                2'b01:   outstd_cnt <= outstd_cnt - CNT_W'(1);
                default: outstd_cnt <= outstd_cnt;
            endcase
        end
    end

    assign bus.outstd_cnt = outstd_cnt;

    // ------------------------------------------------------------------
    // Protocol-violation checks (a done pulse before its lane handshake
    // ends up in one of these)
    // ------------------------------------------------------------------
    for (genvar g = 0; g < IN_NB; g++) begin : g_cnt_chk
        a_cnt_ovf: assert property (@(posedge clk) disable iff (!s_rst_n)
            !(bus.lane_done[g] && !sync_pop && (done_cnt[g] == CNT_W'(OUTSTD_MAX))))
            else $fatal(1, "done counter overflow on lane %0d", g);
    end

    a_pop_empty: assert property (@(posedge clk) disable iff (!s_rst_n)
        !(sync_pop && (fifo_cnt == '0)))
        else $fatal(1, "sync-pop with ID FIFO empty");

    a_push_full: assert property (@(posedge clk) disable iff (!s_rst_n)
        !(fifo_push && (fifo_cnt == CNT_W'(OUTSTD_MAX))))
        else $fatal(1, "ID FIFO push while full");

endmodule

// File: tb/tb_pep_mmacc_splitc_sxt_sched.sv
// ---------------------------------------------------------------------------
// tb_pep_mmacc_splitc_sxt_sched
//   Directed bench for the sign-extension split scheduler: a two-lane
//   instance carries most scenarios, a one-lane instance checks that the
//   single-lane case follows the same timing.
//   Inputs are driven just after a rising edge, outputs sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_pep_mmacc_splitc_sxt_sched;
    localparam int ID_W       = 8;
    localparam int OUTSTD_MAX = 4;
    localparam int CNT_W      = $clog2(OUTSTD_MAX + 1);

    logic clk;
    logic s_rst_n;
    logic dbg_state;
    logic dbg_state1;

    int n_checks;
    int n_fail;

    pep_mmacc_splitc_sxt_sched_if #(.IN_NB(2), .OUTSTD_MAX(OUTSTD_MAX), .ID_W(ID_W)) bus  ();
    pep_mmacc_splitc_sxt_sched_if #(.IN_NB(1), .OUTSTD_MAX(OUTSTD_MAX), .ID_W(ID_W)) bus1 ();

    pep_mmacc_splitc_sxt_sched #(.IN_NB(2), .OUTSTD_MAX(OUTSTD_MAX), .ID_W(ID_W)) dut (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    pep_mmacc_splitc_sxt_sched #(.IN_NB(1), .OUTSTD_MAX(OUTSTD_MAX), .ID_W(ID_W)) dut1 (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .bus       (bus1.slave),
        .dbg_state (dbg_state1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "global timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a command on the 2-lane DUT until accepted (bounded); returns
    // just after the accepting edge with in_cmd_vld dropped.
    task automatic issue_cmd(input logic [ID_W-1:0] id);
        int k;
        bus.in_cmd_vld = 1'b1;
        bus.in_cmd_id  = id;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_cmd_rdy) break;
            cyc();
        end
        n_checks++;
        if (k == 20) begin
            n_fail++;
            $display("FAIL issue_timeout: in_cmd_rdy=0 for 20 cycles, required 1 (id %h)", id);
        end
        cyc();
        bus.in_cmd_vld = 1'b0;
    endtask

    // One-cycle lane_done pulse on the 2-lane DUT.
    task automatic pulse_done(input logic [1:0] lanes);
        bus.lane_done = lanes;
        cyc();
        bus.lane_done = 2'b00;
    endtask

    // Wait (bounded) for out_done_vld; returns at the falling edge where it
    // is seen, or after the bound with ok = 0.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_done_vld) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %b want 0", dbg_state); end
        n_checks++; if (bus.lane_cmd_vld !== 2'b00) begin n_fail++; $display("FAIL rst_lane_vld: got %b want 00", bus.lane_cmd_vld); end
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld: got %b want 0", bus.out_done_vld); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL rst_outstd: got %0d want 0", bus.outstd_cnt); end
        n_checks++; if (bus1.lane_cmd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_lane_vld_1ln: got %b want 0", bus1.lane_cmd_vld); end
        cyc();
        s_rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_release_rdy: got %b want 1", bus.in_cmd_rdy); end
        cyc();
    endtask

    task automatic test_single();
        bit ok;
        bus.lane_cmd_rdy = 2'b11;
        bus.out_done_rdy = 1'b1;
        bus.in_cmd_vld   = 1'b1;
        bus.in_cmd_id    = 8'h12;
        @(negedge clk);   // cycle T
        n_checks++; if (bus.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy_T: got %b want 1", bus.in_cmd_rdy); end
        cyc();
        bus.in_cmd_vld = 1'b0;
        @(negedge clk);   // cycle T+1
        n_checks++; if (bus.lane_cmd_vld !== 2'b11) begin n_fail++; $display("FAIL single_lane_vld_T1: got %b want 11", bus.lane_cmd_vld); end
        n_checks++; if (bus.lane_cmd_id !== 8'h12) begin n_fail++; $display("FAIL single_lane_id: got %h want 12", bus.lane_cmd_id); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL single_outstd: got %0d want 1", bus.outstd_cnt); end
        n_checks++; if (bus.in_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL single_rdy_issue: got %b want 0", bus.in_cmd_rdy); end
        cyc();
        @(negedge clk);   // cycle T+2
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL single_idle_T2: got %b want 0", dbg_state); end
        n_checks++; if (bus.lane_cmd_vld !== 2'b00) begin n_fail++; $display("FAIL single_lane_vld_T2: got %b want 00", bus.lane_cmd_vld); end
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL single_no_early_done: got %b want 0", bus.out_done_vld); end
        pulse_done(2'b11);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout: out_done_vld=0, required 1"); end
        n_checks++; if (bus.out_done_id !== 8'h12) begin n_fail++; $display("FAIL single_done_id: got %h want 12", bus.out_done_id); end
        cyc();
        @(negedge clk);
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL single_done_clear: got %b want 0", bus.out_done_vld); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL single_outstd_end: got %0d want 0", bus.outstd_cnt); end
        cyc();
    endtask

    task automatic test_skew_issue();
        bit ok;
        bus.lane_cmd_rdy = 2'b00;
        bus.in_cmd_vld   = 1'b1;
        bus.in_cmd_id    = 8'h21;
        cyc();            // accepted at end of T (state was IDLE, cnt 0)
        bus.in_cmd_vld   = 1'b0;
        bus.lane_cmd_rdy = 2'b01;
        @(negedge clk);   // T+1
        n_checks++; if (bus.lane_cmd_vld !== 2'b11) begin n_fail++; $display("FAIL skew_vld_T1: got %b want 11", bus.lane_cmd_vld); end
        cyc();
        for (int t = 2; t <= 4; t++) begin
            @(negedge clk);
            n_checks++; if (bus.lane_cmd_vld !== 2'b10) begin n_fail++; $display("FAIL skew_vld_T%0d: got %b want 10", t, bus.lane_cmd_vld); end
            n_checks++; if (bus.in_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL skew_rdy_T%0d: got %b want 0", t, bus.in_cmd_rdy); end
            cyc();
        end
        bus.lane_cmd_rdy = 2'b11;
        @(negedge clk);   // T+5
        n_checks++; if (bus.lane_cmd_vld !== 2'b10) begin n_fail++; $display("FAIL skew_vld_T5: got %b want 10", bus.lane_cmd_vld); end
        n_checks++; if (bus.in_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL skew_rdy_T5: got %b want 0", bus.in_cmd_rdy); end
        cyc();
        @(negedge clk);   // T+6
        n_checks++; if (bus.lane_cmd_vld !== 2'b00) begin n_fail++; $display("FAIL skew_vld_T6: got %b want 00", bus.lane_cmd_vld); end
        n_checks++; if (bus.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL skew_rdy_T6: got %b want 1", bus.in_cmd_rdy); end
        pulse_done(2'b11);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL skew_done_timeout: out_done_vld=0, required 1"); end
        n_checks++; if (bus.out_done_id !== 8'h21) begin n_fail++; $display("FAIL skew_done_id: got %h want 21", bus.out_done_id); end
        cyc();
    endtask

    task automatic test_skew_done();
        bit ok;
        bus.lane_cmd_rdy = 2'b11;
        bus.out_done_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) issue_cmd(ID_W'(i));
        repeat (2) cyc();
        for (int i = 0; i < 3; i++) pulse_done(2'b01);
        repeat (2) cyc();
        @(negedge clk);
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL skewdone_held: got %b want 0", bus.out_done_vld); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL skewdone_outstd: got %0d want 3", bus.outstd_cnt); end
        cyc();
        for (int i = 1; i <= 3; i++) begin
            pulse_done(2'b10);
            wait_done(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL skewdone_timeout_%0d: out_done_vld=0, required 1", i); end
            n_checks++; if (bus.out_done_id !== ID_W'(i)) begin n_fail++; $display("FAIL skewdone_id_%0d: got %h want %h", i, bus.out_done_id, ID_W'(i)); end
            cyc();
        end
        @(negedge clk);
        n_checks++; if (bus.outstd_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL skewdone_outstd_end: got %0d want 0", bus.outstd_cnt); end
        cyc();
    endtask

    task automatic test_back_pressure();
        bus.lane_cmd_rdy = 2'b11;
        bus.out_done_rdy = 1'b0;
        for (int i = 0; i < 4; i++) issue_cmd(ID_W'(8'h40 + i));
        repeat (2) cyc();
        @(negedge clk);
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", dbg_state); end
        n_checks++; if (bus.in_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full: got %b want 0", bus.in_cmd_rdy); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(4)) begin n_fail++; $display("FAIL bp_outstd_full: got %0d want 4", bus.outstd_cnt); end
        cyc();
        // four done pulses on both lanes; the second coincides with the first pop
        for (int i = 0; i < 4; i++) pulse_done(2'b11);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_checks++; if (bus.out_done_vld !== 1'b1) begin n_fail++; $display("FAIL bp_hold_vld_%0d: got %b want 1", t, bus.out_done_vld); end
            n_checks++; if (bus.out_done_id !== 8'h40) begin n_fail++; $display("FAIL bp_hold_id_%0d: got %h want 40", t, bus.out_done_id); end
            cyc();
        end
        bus.out_done_rdy = 1'b1;
        cyc();
        bus.out_done_rdy = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.outstd_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL bp_outstd_3: got %0d want 3", bus.outstd_cnt); end
        n_checks++; if (bus.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_after: got %b want 1", bus.in_cmd_rdy); end
        n_checks++; if (bus.out_done_vld !== 1'b1) begin n_fail++; $display("FAIL bp_next_vld: got %b want 1", bus.out_done_vld); end
        n_checks++; if (bus.out_done_id !== 8'h41) begin n_fail++; $display("FAIL bp_next_id: got %h want 41", bus.out_done_id); end
        bus.out_done_rdy = 1'b1;
        cyc();
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (bus.out_done_vld !== 1'b1) begin n_fail++; $display("FAIL bp_stream_vld_%0d: got %b want 1", k, bus.out_done_vld); end
            n_checks++; if (bus.out_done_id !== ID_W'(8'h40 + k)) begin n_fail++; $display("FAIL bp_stream_id_%0d: got %h want %h", k, bus.out_done_id, ID_W'(8'h40 + k)); end
            cyc();
        end
        @(negedge clk);
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drained_vld: got %b want 0", bus.out_done_vld); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL bp_drained_outstd: got %0d want 0", bus.outstd_cnt); end
        cyc();
    endtask

    task automatic test_simultaneous();
        bit ok;
        bus.lane_cmd_rdy = 2'b11;
        bus.out_done_rdy = 1'b0;
        issue_cmd(8'h55);
        cyc();
        pulse_done(2'b11);
        repeat (3) cyc();
        bus.in_cmd_vld   = 1'b1;
        bus.in_cmd_id    = 8'h56;
        bus.out_done_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL sim_pre_rdy: got %b want 1", bus.in_cmd_rdy); end
        n_checks++; if (bus.out_done_vld !== 1'b1) begin n_fail++; $display("FAIL sim_pre_vld: got %b want 1", bus.out_done_vld); end
        n_checks++; if (bus.out_done_id !== 8'h55) begin n_fail++; $display("FAIL sim_pre_id: got %h want 55", bus.out_done_id); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL sim_pre_outstd: got %0d want 1", bus.outstd_cnt); end
        cyc();
        bus.in_cmd_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.outstd_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL sim_outstd_same: got %0d want 1", bus.outstd_cnt); end
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL sim_vld_clear: got %b want 0", bus.out_done_vld); end
        n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL sim_issue: got %b want 1", dbg_state); end
        cyc();
        cyc();
        pulse_done(2'b11);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_done_timeout: out_done_vld=0, required 1"); end
        n_checks++; if (bus.out_done_id !== 8'h56) begin n_fail++; $display("FAIL sim_done_id: got %h want 56", bus.out_done_id); end
        cyc();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.lane_cmd_rdy = 2'b11;
        bus.out_done_rdy = 1'b1;
        issue_cmd(8'h50);
        cyc();
        bus.lane_cmd_rdy = 2'b01;
        issue_cmd(8'h51);
        cyc();
        @(negedge clk);
        n_checks++; if (bus.lane_cmd_vld !== 2'b10) begin n_fail++; $display("FAIL rmid_pre_vld: got %b want 10", bus.lane_cmd_vld); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL rmid_pre_outstd: got %0d want 2", bus.outstd_cnt); end
        cyc();
        s_rst_n          = 1'b0;
        bus.lane_cmd_rdy = 2'b00;
        repeat (2) cyc();
        s_rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.lane_cmd_vld !== 2'b00) begin n_fail++; $display("FAIL rmid_lane_vld: got %b want 00", bus.lane_cmd_vld); end
        n_checks++; if (bus.out_done_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_out_vld: got %b want 0", bus.out_done_vld); end
        n_checks++; if (bus.outstd_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL rmid_outstd: got %0d want 0", bus.outstd_cnt); end
        n_checks++; if (bus.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy: got %b want 1", bus.in_cmd_rdy); end
        n_checks++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got %b want 0", dbg_state); end
        cyc();
        // a fresh command must come back with its own ID, not a discarded one
        bus.lane_cmd_rdy = 2'b11;
        issue_cmd(8'h60);
        cyc();
        pulse_done(2'b11);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_done_timeout: out_done_vld=0, required 1"); end
        n_checks++; if (bus.out_done_id !== 8'h60) begin n_fail++; $display("FAIL rmid_done_id: got %h want 60", bus.out_done_id); end
        cyc();
    endtask

    task automatic test_single_lane();
        bit ok;
        bus1.lane_cmd_rdy = 1'b1;
        bus1.out_done_rdy = 1'b1;
        bus1.in_cmd_vld   = 1'b1;
        bus1.in_cmd_id    = 8'h7A;
        @(negedge clk);
        n_checks++; if (bus1.in_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL one_rdy_T: got %b want 1", bus1.in_cmd_rdy); end
        cyc();
        bus1.in_cmd_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (bus1.lane_cmd_vld !== 1'b1) begin n_fail++; $display("FAIL one_vld_T1: got %b want 1", bus1.lane_cmd_vld); end
        n_checks++; if (bus1.lane_cmd_id !== 8'h7A) begin n_fail++; $display("FAIL one_lane_id: got %h want 7a", bus1.lane_cmd_id); end
        cyc();
        @(negedge clk);
        n_checks++; if (dbg_state1 !== 1'b0) begin n_fail++; $display("FAIL one_idle_T2: got %b want 0", dbg_state1); end
        cyc();
        bus1.lane_done = 1'b1;
        cyc();
        bus1.lane_done = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus1.out_done_vld) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL one_done_timeout: out_done_vld=0, required 1"); end
        n_checks++; if (bus1.out_done_id !== 8'h7A) begin n_fail++; $display("FAIL one_done_id: got %h want 7a", bus1.out_done_id); end
        cyc();
        @(negedge clk);
        n_checks++; if (bus1.outstd_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL one_outstd_end: got %0d want 0", bus1.outstd_cnt); end
        cyc();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        n_checks          = 0;
        n_fail            = 0;
        s_rst_n           = 1'b0;
        bus.in_cmd_vld    = 1'b0;
        bus.in_cmd_id     = '0;
        bus.lane_cmd_rdy  = 2'b00;
        bus.lane_done     = 2'b00;
        bus.out_done_rdy  = 1'b0;
        bus1.in_cmd_vld   = 1'b0;
        bus1.in_cmd_id    = '0;
        bus1.lane_cmd_rdy = 1'b0;
        bus1.lane_done    = 1'b0;
        bus1.out_done_rdy = 1'b0;

        test_reset();
        test_single();
        test_skew_issue();
        test_skew_done();
        test_back_pressure();
        test_simultaneous();
        test_reset_mid();
        test_single_lane();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pep_mmacc_splitc_sxt_sched.md
PEP_MMACC_SPLITC_SXT_SCHED -- requirements
Module: pep_mmacc_splitc_sxt_sched

Interface
REQ-001 Parameter IN_NB, default 2: number of sign-extension lanes that receive each command.
REQ-002 Parameter OUTSTD_MAX, default 4: maximum number of commands in flight, from input accept to done accept.
REQ-003 Parameter ID_W, default 8: width of the command ID.
REQ-004 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-005 s_rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_cmd_vld / in_cmd_rdy  input / output  1 / 1  command handshake.
REQ-007 in_cmd_id  input  ID_W  command ID.
REQ-008 lane_cmd_vld / lane_cmd_rdy  output / input  IN_NB / IN_NB  per-lane command handshake.
REQ-009 lane_cmd_id  output  ID_W  held command ID, shared by all lanes.
REQ-010 lane_done  input  IN_NB  one-cycle completion pulse per lane; one pulse per command accepted by that lane.
REQ-011 out_done_vld / out_done_rdy  output / input  1 / 1  synchronized done handshake.
REQ-012 out_done_id  output  ID_W  ID of the completed command.
REQ-013 outstd_cnt  output  $clog2(OUTSTD_MAX+1)  number of commands in flight.

Function
REQ-014 Issue FSM SHALL have two states: IDLE (no command held) and ISSUE (broadcasting the held command).
REQ-015 in_cmd_rdy SHALL be 1 only when the state is IDLE and outstd_cnt < OUTSTD_MAX; it SHALL be combinational from registers only.
REQ-016 On an in_cmd handshake, the block SHALL register in_cmd_id into lane_cmd_id, clear the per-lane sent flags, enter ISSUE, and increment outstd_cnt.
REQ-017 In ISSUE, lane_cmd_vld[i] SHALL equal !sent[i]; first assertion is in the cycle after in_cmd accept (1-cycle latency).
REQ-018 Lane handshakes SHALL be independent (fork): sent[i] is set on lane_cmd_vld[i] && lane_cmd_rdy[i], and lane_cmd_vld[i] SHALL drop the following cycle.
REQ-019 When all lanes are sent, counting same-cycle handshakes, the block SHALL push lane_cmd_id into an ID FIFO of depth OUTSTD_MAX and return to IDLE in the next cycle.
REQ-020 Each lane SHALL have a done counter of width $clog2(OUTSTD_MAX+1):
  - increment on lane_done[i];
  - decrement on a sync-pop;
  - increment and decrement in the same cycle SHALL leave the counter unchanged.
REQ-021 A sync-pop SHALL occur when every done counter is > 0 and (!out_done_vld || out_done_rdy).
REQ-022 On a sync-pop, the block SHALL pop the ID FIFO head into out_done_id and set out_done_vld in the next cycle.
REQ-023 out_done_vld SHALL clear on out_done_rdy when no sync-pop occurs in the same cycle; sustained throughput SHALL be 1 done per cycle.
REQ-024 out_done_vld and out_done_id SHALL stay stable while out_done_rdy = 0.
REQ-025 outstd_cnt SHALL decrement on an out_done handshake; simultaneous accept and done handshakes SHALL leave it unchanged.
REQ-026 A lane_done pulse before that lane's command handshake is illegal; simulation assertions SHALL fatal on:
  - done counter overflow beyond OUTSTD_MAX;
  - a sync-pop with the FIFO empty;
  - a FIFO push when the FIFO is full.
REQ-027 For IN_NB = 1, behaviour SHALL be identical to IN_NB > 1; no special-case bypass.

Reset
REQ-028 While s_rst_n = 0, state SHALL be IDLE and all of the following SHALL be 0: sent flags, done counters, FIFO pointers, outstd_cnt, out_done_vld, lane_cmd_vld.
REQ-029 Reset asserted mid-ISSUE or with commands in flight SHALL discard all commands; in_cmd_rdy SHALL be 1 in the first cycle after reset release.
REQ-030 lane_cmd_id and out_done_id are not reset; their values SHALL be don't-care while the corresponding valid is 0.

Verification
REQ-031 Single command ID=0x12 with all lane_cmd_rdy=1 -> both lane_cmd_vld high in cycle T+1, FIFO push, IDLE at T+2; lane_done on both lanes -> out_done_vld=1, out_done_id=0x12 one cycle after the last pulse.
REQ-032 Skewed lanes: lane0 rdy at T+1, lane1 rdy at T+5 -> lane_cmd_vld[0] drops at T+2, lane_cmd_vld[1] held until T+5, in_cmd_rdy=0 until T+6.
REQ-033 Skewed done: lane0 gives 3 pulses (IDs 1,2,3) before lane1 gives any -> no out_done; each subsequent lane1 pulse releases IDs 1, 2, 3 in order.
REQ-034 Back-pressure: 4 commands in flight, out_done_rdy=0 -> in_cmd_rdy=0 with outstd_cnt=4; out_done_rdy=1 for one cycle -> outstd_cnt=3, in_cmd_rdy=1 the next cycle.
REQ-035 Simultaneous events: in_cmd accept and out_done accept in the same cycle -> outstd_cnt unchanged; lane_done and sync-pop in the same cycle -> that lane's counter unchanged.
REQ-036 Reset mid-ISSUE with lane1 unsent and 2 commands in flight -> after release, all valids are 0, outstd_cnt=0, in_cmd_rdy=1.
